// File: rtl/cost_table_arbiter.sv
// cost_table_arbiter: 64 x 7 cost table with a load port and two read
// requesters. Reads are arbitrated round-robin. A requester can lock the
// table for a burst of up to 8 reads. Grants are combinational, and read
// data is registered one cycle after the grant.
module cost_table_arbiter (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LD_EN,
  input  logic [5:0] LD_ADDR,
  input  logic [6:0] LD_DATA,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       LOCK0,
  input  logic       LOCK1,
  input  logic [2:0] W0,
  input  logic [2:0] J0,
  input  logic [2:0] W1,
  input  logic [2:0] J1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       RVAL0,
  output logic       RVAL1,
  output logic [6:0] COST0,
  output logic [6:0] COST1,
  output logic [1:0] OWNER
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     state_q;
  logic       last_q;      // last granted requester; reset to 1 so requester 0 wins first
  logic [2:0] lock_cnt_q;  // grants issued so far in the current burst
  logic       gnt0;
  logic       gnt1;
  logic [6:0] table_q [64];

  // Grant decode. No grant is issued in a reset or load cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!RST && !LD_EN) begin
      case (state_q)
        IDLE: begin
          if (REQ0 && REQ1) begin
            gnt0 = last_q;
            gnt1 = !last_q;
          end else begin
            gnt0 = REQ0;
            gnt1 = REQ1;
          end
        end
        OWN0:    gnt0 = REQ0;
        OWN1:    gnt1 = REQ1;
        default: ;
      endcase
    end
  end

  assign GNT0  = gnt0;
  assign GNT1  = gnt1;
  assign OWNER = state_q;

  // Ownership FSM. It tracks the lock burst and the round-robin pointer.
  // A burst releases on its 8th grant, or on a grant whose LOCK is low.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (RST) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt0) begin
            last_q <= 1'b0;
            if (LOCK0) begin
              state_q    <= OWN0;
              lock_cnt_q <= 3'd1;
            end
          end else if (gnt1) begin
            last_q <= 1'b1;
            if (LOCK1) begin
              state_q    <= OWN1;
              lock_cnt_q <= 3'd1;
            end
          end
        end
        OWN0: begin
          if (gnt0) begin
            last_q <= 1'b0;
            if (lock_cnt_q == 3'd7 || !LOCK0) begin
              state_q    <= IDLE;
              lock_cnt_q <= 3'd0;
            end else begin
              lock_cnt_q <= lock_cnt_q + 3'd1;
            end
          end
        end
        OWN1: begin
          if (gnt1) begin
            last_q <= 1'b1;
            if (lock_cnt_q == 3'd7 || !LOCK1) begin
              state_q    <= IDLE;
              lock_cnt_q <= 3'd0;
            end else begin
              lock_cnt_q <= lock_cnt_q + 3'd1;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          lock_cnt_q <= 3'd0;
        end
      endcase
    end
  end

  // Cost table storage. It is written by the load port and cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: this table is register-based because reset must clear every entry; a RAM macro could not do that.
      table_q <= '{default: 7'd0};
    end else if (LD_EN) begin
      table_q[LD_ADDR] <= LD_DATA;
    end
  end

  // Registered read port. COSTx holds its last value between grants.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RVAL0 <= 1'b0;
      RVAL1 <= 1'b0;
      COST0 <= 7'd0;
      COST1 <= 7'd0;
    end else begin
      RVAL0 <= gnt0;
      RVAL1 <= gnt1;
      if (gnt0) COST0 <= table_q[{W0, J0}];
      if (gnt1) COST1 <= table_q[{W1, J1}];
    end
  end

endmodule

// File: tb/tb_cost_table_arbiter.sv
// Directed testbench for cost_table_arbiter. Inputs change on the falling
// edge. Grants are sampled 1 ns later. Registered outputs are sampled on the
// next falling edge.
module tb_cost_table_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       LD_EN;
  logic [5:0] LD_ADDR;
  logic [6:0] LD_DATA;
  logic       REQ0, REQ1, LOCK0, LOCK1;
  logic [2:0] W0, J0, W1, J1;
  logic       GNT0, GNT1, RVAL0, RVAL1;
  logic [6:0] COST0, COST1;
  logic [1:0] OWNER;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  cost_table_arbiter dut (
    .CLK     (CLK),
    .RST     (RST),
    .LD_EN   (LD_EN),
    .LD_ADDR (LD_ADDR),
    .LD_DATA (LD_DATA),
    .REQ0    (REQ0),
    .REQ1    (REQ1),
    .LOCK0   (LOCK0),
    .LOCK1   (LOCK1),
    .W0      (W0),
    .J0      (J0),
    .W1      (W1),
    .J1      (J1),
    .GNT0    (GNT0),
    .GNT1    (GNT1),
    .RVAL0   (RVAL0),
    .RVAL1   (RVAL1),
    .COST0   (COST0),
    .COST1   (COST1),
    .OWNER   (OWNER)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, starting at a falling edge.
  // in  = {REQ0, LOCK0, REQ1, LOCK1, LD_EN}
  // gnt = {GNT0, GNT1}. The same pair is expected on {RVAL0, RVAL1} one cycle later.
  // own, c0, c1 give OWNER, COST0 and COST1 after the rising edge.
  task automatic beat(input string tag, input logic [4:0] in, input logic [1:0] gnt,
                      input logic [1:0] own, input logic [6:0] c0, input logic [6:0] c1);
    {REQ0, LOCK0, REQ1, LOCK1, LD_EN} = in;
    #1;
    check({tag, ".gnt"}, 32'({GNT0, GNT1}), 32'(gnt));
    @(negedge CLK);
    check({tag, ".rval"},  32'({RVAL0, RVAL1}), 32'(gnt));
    check({tag, ".owner"}, 32'(OWNER), 32'(own));
    check({tag, ".cost0"}, 32'(COST0), 32'(c0));
    check({tag, ".cost1"}, 32'(COST1), 32'(c1));
  endtask

  initial begin
    // Reset with a load and both requests active. All of them must be ignored.
    RST = 1'b1; LD_EN = 1'b1; LD_ADDR = 6'h1D; LD_DATA = 7'h55;
    REQ0 = 1'b1; REQ1 = 1'b1; LOCK0 = 1'b0; LOCK1 = 1'b0;
    W0 = 3'd3; J0 = 3'd5; W1 = 3'd6; J1 = 3'd2;
    #1;
    check("rst.gnt", 32'({GNT0, GNT1}), 32'(2'b00));
    @(negedge CLK);
    @(negedge CLK);
    check("rst.owner", 32'(OWNER), 32'(2'd0));
    check("rst.rval",  32'({RVAL0, RVAL1}), 32'(2'b00));
    check("rst.cost0", 32'(COST0), 32'(7'd0));
    check("rst.cost1", 32'(COST1), 32'(7'd0));
    RST = 1'b0;

    // After reset, requester 0 wins first. The entry at 0x1D is still 0.
    beat("first0", 5'b10100, 2'b10, 2'd0, 7'd0, 7'd0);
    beat("first1", 5'b10100, 2'b01, 2'd0, 7'd0, 7'd0);

    // Load table[a] = a. No grant is allowed in a load cycle.
    LD_ADDR = 6'd0; LD_DATA = 7'd0;
    beat("ld_nogrant", 5'b10001, 2'b00, 2'd0, 7'd0, 7'd0);
    for (int a = 1; a < 64; a++) begin
      LD_ADDR = 6'(a); LD_DATA = 7'(a); LD_EN = 1'b1; REQ0 = 1'b0;
      @(negedge CLK);
    end

    // Single read of W=3, J=5 returns 29. COST0 then holds its value.
    beat("rd29", 5'b10000, 2'b10, 2'd0, 7'd29, 7'd0);
    beat("hold", 5'b00000, 2'b00, 2'd0, 7'd29, 7'd0);

    // Both requesters active without lock. LAST=0 here, so grants go 1,0,1,0,1.
    for (int i = 0; i < 5; i++)
      beat("alt", 5'b10100, (i % 2 == 0) ? 2'b01 : 2'b10, 2'd0, 7'd29, 7'd50);

    // Locked burst by requester 0 while requester 1 waits: 8 grants, then requester 1.
    W0 = 3'd0; J0 = 3'd7; W1 = 3'd1; J1 = 3'd1;
    for (int i = 0; i < 8; i++)
      beat("burst", 5'b11100, 2'b10, (i < 7) ? 2'd1 : 2'd0, 7'd7, 7'd50);
    beat("burst9", 5'b11100, 2'b01, 2'd0, 7'd7, 7'd9);

    // Load during OWN0 to 0x1D. The counter freezes, so the release moves to the 9th cycle.
    W0 = 3'd3; J0 = 3'd5; LD_ADDR = 6'h1D; LD_DATA = 7'h55;
    for (int i = 0; i < 9; i++)
      beat("ldlock", (i == 2) ? 5'b11001 : 5'b11000, (i == 2) ? 2'b00 : 2'b10,
           (i == 8) ? 2'd0 : 2'd1, (i < 3) ? 7'd29 : 7'h55, 7'd9);

    // OWN1 with REQ1 dropped for 3 cycles while REQ0 waits.
    W0 = 3'd0; J0 = 3'd7; W1 = 3'd2; J1 = 3'd3;
    beat("own1_a",   5'b10110, 2'b01, 2'd2, 7'h55, 7'd19);
    beat("own1_b",   5'b10110, 2'b01, 2'd2, 7'h55, 7'd19);
    for (int i = 0; i < 3; i++)
      beat("own1_gap", 5'b10000, 2'b00, 2'd2, 7'h55, 7'd19);
    beat("own1_res", 5'b10110, 2'b01, 2'd2, 7'h55, 7'd19);
    beat("own1_rel", 5'b10100, 2'b01, 2'd0, 7'h55, 7'd19);
    beat("after_rel", 5'b10100, 2'b10, 2'd0, 7'd7, 7'd19);

    // Reset on the 4th beat of a locked burst.
    W0 = 3'd3; J0 = 3'd5;
    for (int i = 0; i < 3; i++)
      beat("pre_rst", 5'b11000, 2'b10, 2'd1, 7'h55, 7'd19);
    RST = 1'b1;
    #1;
    check("midrst.gnt", 32'({GNT0, GNT1}), 32'(2'b00));
    @(negedge CLK);
    check("midrst.rval",  32'({RVAL0, RVAL1}), 32'(2'b00));
    check("midrst.owner", 32'(OWNER), 32'(2'd0));
    check("midrst.cost0", 32'(COST0), 32'(7'd0));
    RST = 1'b0;
    beat("cleared0", 5'b10100, 2'b10, 2'd0, 7'd0, 7'd0);
    beat("cleared1", 5'b00100, 2'b01, 2'd0, 7'd0, 7'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
